pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 16: width of each data channel.
REQ-002 Parameter NUM_DATA, default 2: number of data channels carried (e.g. data_2 and ALU_out).
REQ-003 Parameter CTRL_W, default 5: width of the control-bit bundle (e.g. createdump, write_mem, read_mem, mem_to_reg, reg_w_en).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low; assertion clears state immediately, deassertion sampled on clk.
REQ-006 flush  input  1  synchronous squash of all held and incoming entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage accepts an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-010 in_data  input  NUM_DATA*DATA_W  upstream data, channel k at bits [k*DATA_W +: DATA_W].
REQ-011 out_valid  output  1  downstream entry present.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 out_ctrl  output  CTRL_W  control bundle of head entry; all zero whenever out_valid=0.
REQ-014 out_data  output  NUM_DATA*DATA_W  data of head entry; value unspecified when out_valid=0.
REQ-015 occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 Storage: main entry (head, drives outputs) plus one skid entry; each entry = valid bit, CTRL_W control, NUM_DATA*DATA_W data.
REQ-017 States: EMPTY (occupancy 0), ONE (main valid only), FULL (main and skid valid); skid valid without main valid is illegal and never reached.
REQ-018 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-019 in_ready = (state != FULL), driven from registered state only; no combinational path from out_ready or in_valid to in_ready.
REQ-020 out_valid = main valid; out_ctrl/out_data driven directly from main entry registers (no combinational path from inputs).
REQ-021 Latency: entry accepted at edge N, in EMPTY, appears on outputs after edge N (one cycle).
REQ-022 EMPTY: in_fire -> load main, go ONE; else stay.
REQ-023 ONE: in_fire & out_fire -> load main with input, stay ONE; in_fire & !out_fire -> load skid, go FULL; !in_fire & out_fire -> go EMPTY; neither -> hold.
REQ-024 FULL: out_fire -> move skid to main, go ONE; else hold (in_ready=0, no input accepted).
REQ-025 Order preserved: entries leave in acceptance order; no entry dropped or duplicated except by flush.
REQ-026 Held entries keep ctrl and data bit-exact while not popped (stall = out_ready low).
REQ-027 flush=1 at an edge -> both valid bits cleared, go EMPTY, any same-cycle in_fire entry discarded; flush overrides all other transitions.
REQ-028 Control bits of an invalid entry are cleared when it is invalidated, so out_ctrl=0 in EMPTY (bubble carries no reg_w_en/write_mem).
REQ-029 Data registers need not clear on pop/flush; only valid and ctrl are required to clear.
REQ-030 occupancy = 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-031 rst low -> immediately state EMPTY, all valid and ctrl bits 0, out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, data registers 0.
REQ-032 Reset mid-operation discards all held entries; first accept after release behaves as from EMPTY.

Verification
REQ-033 Reset, then in_valid=1, in_ctrl=5'b10011, in_data={16'h1234,16'hABCD}, out_ready=1 -> next cycle out_valid=1, out_ctrl=5'b10011, out_data={16'h1234,16'hABCD}, occupancy=1.
REQ-034 out_ready=0, push A (ctrl 1) then B (ctrl 2) back-to-back -> occupancy 2, in_ready=0, out shows A; raise out_ready -> A popped, then B, occupancy 1 then 0; third push while FULL not accepted.
REQ-035 Continuous in_valid=1, out_ready=1, 8 entries data 0..7 -> one entry per cycle, outputs 0..7 in order, occupancy stays 1, in_ready stays 1.
REQ-036 FULL with in_valid=1, assert flush one cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; flushed input never appears.
REQ-037 Random in_valid/out_ready (50% each, 1000 cycles) vs. reference FIFO model -> identical output sequence, occupancy never 3, out_ctrl=0 whenever out_valid=0.
REQ-038 Assert rst low asynchronously between edges while FULL -> outputs clear before next clk edge; after release, push C -> C emerges after one cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - Two-entry pipeline register stage with skid buffer.
// The main entry drives the outputs; the skid entry absorbs one beat while downstream stalls.
module pipe_stage_skid #(
  parameter int DATA_W   = 16,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [1:0]                 occupancy
);

  localparam int TOT_W = NUM_DATA * DATA_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [CTRL_W-1:0]  main_ctrl;
  logic [TOT_W-1:0]   main_data;
  logic [CTRL_W-1:0]  skid_ctrl;
  logic [TOT_W-1:0]   skid_data;
  logic               in_fire;
  logic               out_fire;

  // Handshake outputs depend only on registered state, never on in_valid/out_ready.
  assign in_ready  = (state != S_FULL);
  assign out_valid = (state != S_EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      S_EMPTY: occupancy = 2'd0;
      S_ONE:   occupancy = 2'd1;
      S_FULL:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Control bits are zeroed whenever an entry is invalidated so a bubble carries no side effects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            state     <= S_FULL;
          end else if (out_fire) begin
            main_ctrl <= '0;
            state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_ctrl <= '0;
            state     <= S_ONE;
          end
        end
        default: begin
          state     <= S_EMPTY;
          main_ctrl <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - Scoreboard bench for pipe_stage_skid against a two-deep FIFO model.
module tb_pipe_stage_skid;
  localparam int DW = 16;
  localparam int ND = 2;
  localparam int CW = 5;
  localparam int TW = ND * DW;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [TW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [TW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [TW-1:0] out_data;
  logic [1:0]    occupancy;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  pipe_stage_skid #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the head against the model FIFO, then advances the model with the
  // handshakes that the coming rising edge will see.
  always @(negedge clk) begin
    ent_t head;
    bit   acc;
    if (!rst) begin
      exp_q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      chk("occupancy", occupancy, exp_q.size());
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        chk("out_ctrl", out_ctrl, head.c);
        chk("out_data", out_data, head.d);
      end else begin
        chk("bubble_ctrl", out_ctrl, 0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        acc = in_valid && (exp_q.size() < 2);
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ent_t'{c: in_ctrl, d: in_data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [TW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;

    // Single entry with one cycle latency
    out_ready = 1'b1;
    drive(1'b1, 5'b10011, {16'h1234, 16'hABCD});
    step();
    drive(1'b0, '0, '0);
    chk("t1_valid", out_valid, 1);
    chk("t1_ctrl", out_ctrl, 5'b10011);
    chk("t1_data", out_data, {16'h1234, 16'hABCD});
    chk("t1_occ", occupancy, 1);
    step();

    // Stall: fill both entries, third push refused
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 32'h0000_000A);
    step();
    drive(1'b1, 5'd2, 32'h0000_000B);
    step();
    drive(1'b1, 5'd3, 32'h0000_000C);
    chk("t2_occ_full", occupancy, 2);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_head_a", out_ctrl, 5'd1);
    step();
    chk("t2_third_refused", occupancy, 2);
    chk("t2_head_held", out_data, 32'h0000_000A);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("t2_pop_a_occ", occupancy, 1);
    chk("t2_head_b", out_ctrl, 5'd2);
    step();
    chk("t2_pop_b_occ", occupancy, 0);
    chk("t2_empty_ctrl", out_ctrl, 0);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i + 1), TW'(i));
      step();
      chk("t3_data", out_data, TW'(i));
      chk("t3_occ", occupancy, 1);
      chk("t3_in_ready", in_ready, 1);
    end
    drive(1'b0, '0, '0);
    step();

    // Flush while FULL with a pending input
    out_ready = 1'b0;
    drive(1'b1, 5'd4, 32'h4444_4444);
    step();
    drive(1'b1, 5'd5, 32'h5555_5555);
    step();
    drive(1'b1, 5'd6, 32'h6666_6666);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("t4_valid", out_valid, 0);
    chk("t4_ctrl", out_ctrl, 0);
    chk("t4_occ", occupancy, 0);
    chk("t4_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("t4_no_ghost", out_valid, 0);

    // Asynchronous reset while FULL, then restart
    out_ready = 1'b0;
    drive(1'b1, 5'd8, 32'h8888_0000);
    step();
    drive(1'b1, 5'd9, 32'h9999_0000);
    step();
    drive(1'b0, '0, '0);
    chk("t5_full", occupancy, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_ctrl", out_ctrl, 0);
    chk("t5_async_occ", occupancy, 0);
    chk("t5_async_in_ready", in_ready, 1);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 5'd7, 32'hC0C0_C0C0);
    step();
    drive(1'b0, '0, '0);
    chk("t5_c_valid", out_valid, 1);
    chk("t5_c_ctrl", out_ctrl, 5'd7);
    chk("t5_c_data", out_data, 32'hC0C0_C0C0);
    step();

    // Random traffic; the monitor checks every cycle
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom), TW'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
